// File: rtl/serial_addsub_fsm.sv
// serial_addsub_fsm
// -----------------------------------------------------------------------------
// Bit-serial adder/subtractor. Operands are captured on accept, then one
// full-adder cell processes them LSB-first, one bit per clock, over WIDTH
// cycles. The parallel result and final carry are held after completion.
//
// Optional feature macro: SERIAL_ADDSUB_OVF_EN
//   defined   -> ovf port and signed-overflow register are present
//   undefined -> no ovf port/logic, all other behaviour identical
//
// Handshake: a request is accepted on a rising edge where the FSM is in IDLE
// and start=1 (busy=0 and done=0 at that point). Once accepted, start,
// sub, data_a and data_b are ignored until the FSM returns to IDLE. done is
// a single-cycle pulse, and result/result_carry are valid from that cycle
// until the next accept.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   start        in   request, sampled only in IDLE
//   sub          in   0: A+B, 1: A-B (captured on accept)
//   data_a       in   operand A [WIDTH]
//   data_b       in   operand B [WIDTH]
//   busy         out  1 while in SHIFT
//   done         out  one-cycle result-valid pulse
//   result       out  parallel sum/difference [WIDTH]
//   result_carry out  final carry out of MSB (sub: 1 = no borrow)
//   sum_out      out  serial sum bit of current cycle (0 outside SHIFT)
//   carry_out    out  serial carry of current cycle (0 outside SHIFT)
//   a_bit        out  current A bit (0 outside SHIFT)
//   b_bit        out  current effective B bit (0 outside SHIFT)
//   ovf          out  signed overflow (SERIAL_ADDSUB_OVF_EN only)
//   state_dbg    out  FSM state encoding for debug/checkers
// -----------------------------------------------------------------------------
module serial_addsub_fsm #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             result_carry,
  output logic             sum_out,
  output logic             carry_out,
  output logic             a_bit,
  output logic             b_bit,
`ifdef SERIAL_ADDSUB_OVF_EN
  output logic             ovf,
`endif
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic             c_q, c_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             rc_q, rc_d;
`ifdef SERIAL_ADDSUB_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Full-adder cell on the current bit position.
  logic cur_a, cur_b, fa_sum, fa_carry, last_bit;

  assign cur_a    = a_sr_q[0];
  assign cur_b    = b_sr_q[0];
  assign fa_sum   = cur_a ^ cur_b ^ c_q;
  assign fa_carry = (cur_a & cur_b) | (cur_a & c_q) | (cur_b & c_q);
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    c_d      = c_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    rc_d     = rc_q;
`ifdef SERIAL_ADDSUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SHIFT;
          a_sr_d  = data_a;
          // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
          b_sr_d  = sub ? ~data_b : data_b;
          c_d     = sub;
          cnt_d   = '0;
`ifdef SERIAL_ADDSUB_OVF_EN
          ovf_d   = 1'b0;
`endif
        end
      end
      ST_SHIFT: begin
        result_d = {fa_sum, result_q[WIDTH-1:1]};
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        c_d      = fa_carry;
        cnt_d    = cnt_q + CW'(1);
        if (last_bit) begin
          state_d = ST_DONE;
          rc_d    = fa_carry;
`ifdef SERIAL_ADDSUB_OVF_EN
          // On the MSB cell, c_q is the carry into the MSB.
          ovf_d   = c_q ^ fa_carry;
`endif
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      c_q      <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      rc_q     <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      c_q      <= c_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      rc_q     <= rc_d;
`ifdef SERIAL_ADDSUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign busy         = (state_q == ST_SHIFT);
  assign done         = (state_q == ST_DONE);
  assign result       = result_q;
  assign result_carry = rc_q;
  assign sum_out      = busy & fa_sum;
  assign carry_out    = busy & fa_carry;
  assign a_bit        = busy & cur_a;
  assign b_bit        = busy & cur_b;
  assign state_dbg    = state_q;
`ifdef SERIAL_ADDSUB_OVF_EN
  assign ovf          = ovf_q;
`endif

endmodule
